// File: rtl/pkt_con_ejection_arb.sv
// Ejection arbiter: merges N_X X-direction and N_Y Y-direction requesters into the
// node's single local ejection channel.
//
// Two QoS classes (in_qos_i=1 is high), each with its own round-robin pointer. High class
// wins normally; a starvation guard forces a low-class grant after STARVE_LIM consecutive
// high-class grants taken while low-class requests wait. The winner is registered in a
// single-entry output stage that drains and refills on the same edge.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_vld_i / in_rdy_o / in_qos_i     per-input request, one-hot accept, class
//   in_type_i/in_src_i/in_tgt_i/in_data_i  packed per-input fields, input i at [i*W +: W]
//   out_vld_o / out_rdy_i              output stage handshake
//   out_qos_o/out_type_o/out_src_o/out_tgt_o/out_data_o/out_idx_o  held flit
//   starve_pulse_o                     one cycle, with the flit of a forced low-class grant
module pkt_con_ejection_arb #(
    parameter int unsigned N_X        = 7,
    parameter int unsigned N_Y        = 7,
    parameter int unsigned TYPE_W     = 4,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned FLIT_W     = 32,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_X+N_Y-1:0]            in_vld_i,
    output logic [N_X+N_Y-1:0]            in_rdy_o,
    input  logic [N_X+N_Y-1:0]            in_qos_i,
    input  logic [(N_X+N_Y)*TYPE_W-1:0]   in_type_i,
    input  logic [(N_X+N_Y)*ID_W-1:0]     in_src_i,
    input  logic [(N_X+N_Y)*ID_W-1:0]     in_tgt_i,
    input  logic [(N_X+N_Y)*FLIT_W-1:0]   in_data_i,
    output logic                          out_vld_o,
    input  logic                          out_rdy_i,
    output logic                          out_qos_o,
    output logic [TYPE_W-1:0]             out_type_o,
    output logic [ID_W-1:0]               out_src_o,
    output logic [ID_W-1:0]               out_tgt_o,
    output logic [FLIT_W-1:0]             out_data_o,
    output logic [3:0]                    out_idx_o,
    output logic                          starve_pulse_o
);

    localparam int unsigned N     = N_X + N_Y;
    localparam int unsigned IDX_W = 4;  // out_idx is 4 bits, so N must not exceed 16

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [N-1:0]       hi_req, lo_req, sel_req;
    logic [IDX_W-1:0]   sel_ptr, win_idx, cand_idx, win_next;
    logic [31:0]        cand;
    logic               use_lo, win_vld, load, grant_hi, grant_lo;
    logic [TYPE_W-1:0]  win_type;
    logic [ID_W-1:0]    win_src, win_tgt;
    logic [FLIT_W-1:0]  win_data;

    logic [IDX_W-1:0]   rr_hi_q, rr_hi_d, rr_lo_q, rr_lo_d;
    logic [0:0]         state_q, state_d;
    logic [7:0]         age_q, age_d;
    logic               pulse_q, pulse_d;
    logic               vld_q, vld_d, qos_q, qos_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [ID_W-1:0]    src_q, src_d, tgt_q, tgt_d;
    logic [FLIT_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Winner selection: circular first-set search from the class pointer.
    always_comb begin
        hi_req   = in_vld_i & in_qos_i;
        lo_req   = in_vld_i & ~in_qos_i;
        // FORCE prefers low class; with no low request it falls back to normal priority.
        use_lo   = (hi_req == '0) || (state_q == ST_FORCE && lo_req != '0);
        sel_req  = use_lo ? lo_req : hi_req;
        sel_ptr  = use_lo ? rr_lo_q : rr_hi_q;
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(sel_ptr) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = cand[IDX_W-1:0];
            if (!win_vld && sel_req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
        win_next = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    // Field mux for the winner.
    always_comb begin
        win_type = '0;
        win_src  = '0;
        win_tgt  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_type = in_type_i[i*TYPE_W +: TYPE_W];
                win_src  = in_src_i[i*ID_W +: ID_W];
                win_tgt  = in_tgt_i[i*ID_W +: ID_W];
                win_data = in_data_i[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Handshake, output stage and pointer update.
    always_comb begin
        load     = !vld_q || out_rdy_i;
        grant_hi = load && win_vld && !use_lo;
        grant_lo = load && win_vld && use_lo;
        in_rdy_o = '0;
        if (load && win_vld) in_rdy_o[win_idx] = 1'b1;

        vld_d   = vld_q;
        qos_d   = qos_q;
        type_d  = type_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        rr_hi_d = rr_hi_q;
        rr_lo_d = rr_lo_q;
        if (load) begin
            vld_d = win_vld;
            if (win_vld) begin
                qos_d  = !use_lo;
                type_d = win_type;
                src_d  = win_src;
                tgt_d  = win_tgt;
                data_d = win_data;
                idx_d  = win_idx;
                if (use_lo) rr_lo_d = win_next;
                else        rr_hi_d = win_next;
            end
        end
    end

    // Starvation guard.
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (lo_req == '0 || grant_lo) begin
                    age_d = '0;
                end else if (grant_hi && age_q != 8'hFF) begin
                    age_d = age_q + 8'd1;
                end
                // Enter FORCE on the grant that reaches the limit so the very next grant is low.
                if (lo_req != '0 && age_d == 8'(STARVE_LIM)) state_d = ST_FORCE;
            end
            ST_FORCE: begin
                if (lo_req == '0) begin
                    state_d = ST_NORMAL;
                    age_d   = '0;
                end else if (grant_lo) begin
                    state_d = ST_NORMAL;
                    age_d   = '0;
                    pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                age_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            qos_q   <= 1'b0;
            type_q  <= '0;
            src_q   <= '0;
            tgt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            rr_hi_q <= '0;
            rr_lo_q <= '0;
            state_q <= ST_NORMAL;
            age_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            qos_q   <= qos_d;
            type_q  <= type_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            rr_hi_q <= rr_hi_d;
            rr_lo_q <= rr_lo_d;
            state_q <= state_d;
            age_q   <= age_d;
            pulse_q <= pulse_d;
        end
    end

    assign out_vld_o      = vld_q;
    assign out_qos_o      = qos_q;
    assign out_type_o     = type_q;
    assign out_src_o      = src_q;
    assign out_tgt_o      = tgt_q;
    assign out_data_o     = data_q;
    assign out_idx_o      = idx_q;
    assign starve_pulse_o = pulse_q;

endmodule

// File: tb/tb_pkt_con_ejection_arb.sv
// Directed bench for pkt_con_ejection_arb with hand-computed expected grants.
module tb_pkt_con_ejection_arb;

    localparam int unsigned N      = 14;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned FLIT_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           in_vld, in_rdy, in_qos;
    logic [N*TYPE_W-1:0]    in_type;
    logic [N*ID_W-1:0]      in_src, in_tgt;
    logic [N*FLIT_W-1:0]    in_data;
    logic                   out_vld, out_rdy, out_qos, starve_pulse;
    logic [TYPE_W-1:0]      out_type;
    logic [ID_W-1:0]        out_src, out_tgt;
    logic [FLIT_W-1:0]      out_data;
    logic [3:0]             out_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pkt_con_ejection_arb #(
        .N_X        (7),
        .N_Y        (7),
        .TYPE_W     (TYPE_W),
        .ID_W       (ID_W),
        .FLIT_W     (FLIT_W),
        .STARVE_LIM (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_vld_i       (in_vld),
        .in_rdy_o       (in_rdy),
        .in_qos_i       (in_qos),
        .in_type_i      (in_type),
        .in_src_i       (in_src),
        .in_tgt_i       (in_tgt),
        .in_data_i      (in_data),
        .out_vld_o      (out_vld),
        .out_rdy_i      (out_rdy),
        .out_qos_o      (out_qos),
        .out_type_o     (out_type),
        .out_src_o      (out_src),
        .out_tgt_o      (out_tgt),
        .out_data_o     (out_data),
        .out_idx_o      (out_idx),
        .starve_pulse_o (starve_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive requests; every input carries fields derived from its own index.
    task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] qos);
        in_vld = vld;
        in_qos = qos;
        for (int i = 0; i < N; i++) begin
            in_type[i*TYPE_W +: TYPE_W] = 4'(i);
            in_src[i*ID_W +: ID_W]      = 8'(i) + 8'h10;
            in_tgt[i*ID_W +: ID_W]      = 8'(i) | 8'h80;
            in_data[i*FLIT_W +: FLIT_W] = 32'hD000_0000 | 32'(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    int seq_hl [9] = '{2, 9, 2, 9, 2, 9, 2, 9, 5};

    initial begin
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        drive('0, '0);
        #12;
        rst_n = 1'b1;

        // Reset state and idle.
        check("rst_out_vld", out_vld, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pulse", starve_pulse, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_out_vld", out_vld, 0);
            check("idle_in_rdy", in_rdy, 0);
            check("idle_pulse", starve_pulse, 0);
        end

        // All 14 low-class requesters: strict rotation 0..13 then 0.
        drive('1, '0);
        for (int k = 0; k < 15; k++) begin
            int e;
            e = k % 14;
            #1;
            check("rr_lo_in_rdy", in_rdy, 64'(1) << e);
            tick();
            check("rr_lo_out_vld", out_vld, 1);
            check("rr_lo_out_idx", out_idx, e);
            check("rr_lo_out_data", out_data, 64'h0D000_0000 | 64'(e));
            check("rr_lo_out_qos", out_qos, 0);
        end
        check("rr_lo_out_src", out_src, 8'h10);
        check("rr_lo_out_tgt", out_tgt, 8'h80);
        check("rr_lo_out_type", out_type, 0);

        // High 2 and 9 against low 5: eight high grants, then a forced grant of 5.
        drive(bits3(2, 9, 5), bits3(2, 9, -1));
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 9; j++) begin
                int e;
                e = seq_hl[j];
                #1;
                check("starve_in_rdy", in_rdy, 64'(1) << e);
                tick();
                check("starve_out_idx", out_idx, e);
                check("starve_out_qos", out_qos, (e != 5) ? 1 : 0);
                check("starve_pulse", starve_pulse, (e == 5) ? 1 : 0);
            end
        end

        // Back-pressure: input 3 alone, output stalled for 4 cycles.
        drive('0, '0);
        tick();
        check("drain_out_vld", out_vld, 0);
        drive(bits3(3, -1, -1), '0);
        in_data[3*FLIT_W +: FLIT_W] = 32'h0000_00A5;
        #1;
        check("bp_in_rdy_first", in_rdy, 64'(1) << 3);
        tick();
        check("bp_out_vld", out_vld, 1);
        check("bp_out_data", out_data, 32'hA5);
        check("bp_out_idx", out_idx, 3);
        in_data[3*FLIT_W +: FLIT_W] = 32'h0000_005A;
        out_rdy = 1'b0;
        #1;
        check("bp_in_rdy_stall", in_rdy, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("bp_hold_vld", out_vld, 1);
            check("bp_hold_data", out_data, 32'hA5);
            check("bp_hold_in_rdy", in_rdy, 0);
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_in_rdy", in_rdy, 64'(1) << 3);
        tick();
        check("bp_replace_vld", out_vld, 1);
        check("bp_replace_data", out_data, 32'h5A);
        drive('0, '0);
        #1;
        check("bp_done_in_rdy", in_rdy, 0);
        tick();
        check("bp_done_out_vld", out_vld, 0);

        // Pointer wrap 13 -> 0 with no bubble.
        drive(bits3(13, -1, -1), '0);
        #1;
        check("wrap_in_rdy13", in_rdy, 64'(1) << 13);
        tick();
        check("wrap_idx13", out_idx, 13);
        drive(bits3(0, 12, -1), '0);
        #1;
        check("wrap_in_rdy0", in_rdy, 64'(1));
        tick();
        check("wrap_idx0", out_idx, 0);
        check("wrap_vld0", out_vld, 1);
        drive(bits3(1, 12, -1), '0);
        #1;
        check("wrap_in_rdy1", in_rdy, 64'(1) << 1);
        tick();
        check("wrap_idx1", out_idx, 1);

        // Asynchronous reset while a flit is held.
        out_rdy = 1'b0;
        drive('0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_vld", out_vld, 0);
        check("arst_out_idx", out_idx, 0);
        check("arst_out_data", out_data, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        drive('1, '0);
        #1;
        check("arst_first_in_rdy", in_rdy, 64'(1));
        tick();
        check("arst_first_idx", out_idx, 0);
        check("arst_first_vld", out_vld, 1);

        // Low request vanishing while forced: back to normal with no pulse and age cleared.
        drive(bits3(2, 5, -1), bits3(2, -1, -1));
        for (int c = 0; c < 8; c++) begin
            #1;
            check("abort_hi_in_rdy", in_rdy, 64'(1) << 2);
            tick();
        end
        drive(bits3(2, -1, -1), bits3(2, -1, -1));
        #1;
        check("abort_fallback_in_rdy", in_rdy, 64'(1) << 2);
        tick();
        check("abort_no_pulse", starve_pulse, 0);
        drive(bits3(2, 5, -1), bits3(2, -1, -1));
        #1;
        check("abort_age_cleared", in_rdy, 64'(1) << 2);
        tick();
        check("abort_no_pulse2", starve_pulse, 0);
        check("abort_idx", out_idx, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_con_ejection_arb.md
Name: pkt_con_ejection_arb

Overview:
- Node-side arbiter for the slave side of the packet connection bundle: 7 X-direction plus 7 Y-direction inputs merge into one local ejection channel.
- Selects one requester per cycle using two QoS classes, with round-robin inside each class and a starvation guard for the low class.
- Registers the winner in a single-entry output stage.
- Sits between the topology's slave-side connections and the node's local receive logic.

Parameters:
- N_X, 7, number of X-direction inputs (same x coordinate); requester indices 0..N_X-1.
- N_Y, 7, number of Y-direction inputs (same y coordinate); requester indices N_X..N_X+N_Y-1.
- TYPE_W, `TYPE_W, packet type width.
- ID_W, `ID_W, source/target ID width.
- FLIT_W, `FLIT_W, flit payload width.
- STARVE_LIM, 8, consecutive high-class grants tolerated while a low-class request waits; range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  N  request valid per input, N=N_X+N_Y; bits [N_X-1:0] are X, the rest are Y.
- in_rdy  out  N  one-hot (or zero) accept per input.
- in_qos  in  N  1 = high class.
- in_type  in  N*TYPE_W  packed per-input type, input i at [i*TYPE_W +: TYPE_W].
- in_src  in  N*ID_W  packed source IDs.
- in_tgt  in  N*ID_W  packed target IDs.
- in_data  in  N*FLIT_W  packed payloads.
- out_vld  out  1  output register holds a flit.
- out_rdy  in  1  local sink accepts.
- out_qos, out_type, out_src, out_tgt, out_data  out  1/TYPE_W/ID_W/ID_W/FLIT_W  registered winner fields.
- out_idx  out  4  input index of the held flit.
- starve_pulse  out  1  one-cycle pulse when a forced low-class grant occurs.

Behaviour:
- Reset (async assert, sync release):
  - out_vld=0; all out_* fields and out_idx = 0.
  - starve_pulse=0.
  - rr_hi=rr_lo=0; age=0; FSM=NORMAL.
- Handshake rules:
  - Transfer on input i when in_vld[i]&in_rdy[i]; transfer out when out_vld&out_rdy.
  - in_rdy depends only on arbitration state, in_vld, in_qos and out_rdy, never on payload.
  - Senders must hold vld and fields stable until accepted.
- Accept condition: load = !out_vld | out_rdy (full-throughput pass-through).
  - in_rdy is all zeros when !load.
  - Otherwise in_rdy = one-hot of the winner, or zero if no request.
- Winner selection (combinational):
  - HI = in_vld&in_qos; LO = in_vld&~in_qos.
  - NORMAL: if HI≠0, first set bit of HI searching circularly from rr_hi; else first set bit of LO from rr_lo.
  - FORCE: if LO≠0, pick from LO via rr_lo; else fall back as NORMAL.
- On a load with a winner w:
  - Register its fields; out_vld=1 next cycle.
  - If w is high class, rr_hi=(w+1) mod N; otherwise rr_lo=(w+1) mod N.
- On a load with no winner: out_vld=0 if the held flit drained that cycle; otherwise it holds.
- Latency: input accept to out_vld = 1 cycle. Back-to-back accepts every cycle while out_rdy=1.
- Starvation FSM (two states):
  - NORMAL: each high-class grant while LO≠0 sets age=age+1 (saturating at 255).
  - A low-class grant, or LO=0, clears age to 0.
  - When age==STARVE_LIM, move to FORCE.
  - FORCE: the next low-class grant pulses starve_pulse, clears age and returns to NORMAL.
  - If LO becomes 0 while in FORCE, return to NORMAL with age=0 and no pulse.
- Boundaries:
  - out_rdy=0 while full: register and all pointers hold; in_rdy=0.
  - Single requester: granted every load cycle regardless of pointer.
  - Pointer wrap: N-1 → 0.
  - Simultaneous drain and accept: the new flit replaces the old in the same edge, no bubble.
  - Reset mid-transfer: the held flit is discarded; out_vld drops asynchronously.

Test Plan:
- Reset, then in_vld=0x0000, out_rdy=1 → out_vld=0, in_rdy=0, starve_pulse=0 over 10 cycles.
- All 14 low-class valid continuously, out_rdy=1 → grants in order 0,1,…,13,0; out_idx follows one cycle later; one grant per cycle.
- Inputs 2 and 9 high-class, 5 low-class, STARVE_LIM=8:
  - Grants alternate 2,9 for 8 grants, then 5 with starve_pulse=1.
  - Cycle then repeats.
- Input 3 valid with data 0xA5, out_rdy=0 for 4 cycles:
  - out_vld=1 and data 0xA5 held.
  - in_rdy all 0 until out_rdy=1; then in_rdy[3] drops after the accept if in_vld[3] falls.
- out_rdy=1 with continuous input 13 then input 0 → no bubble; rr wraps 13→0 correctly.
- Assert rst_n=0 mid-cycle with out_vld=1 → out_vld=0 immediately; after release, the first grant starts from index 0.
